// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: bundles the video, CPU and aux client ports and the
// controller-side command/response port of the SDRAM arbiter.
// The arbiter connects through the master modport; the surrounding system
// (clients plus controller) uses the slave modport.
interface sdram_arbiter_if #(
   parameter int ADDR_W = 22
);
   // video framebuffer fetch client
   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_rvalid;
   logic              vid_ack;
   // CPU client
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [31:0]       cpu_wdata;
   logic [3:0]        cpu_wmask;
   logic              cpu_rvalid;
   logic              cpu_ack;
   // auxiliary loader/debug client
   logic              aux_req;
   logic              aux_we;
   logic [ADDR_W-1:0] aux_addr;
   logic [31:0]       aux_wdata;
   logic [3:0]        aux_wmask;
   logic              aux_rvalid;
   logic              aux_ack;
   // shared read data
   logic [31:0]       rdata;
   // SDRAM controller port
   logic              mem_req;
   logic              mem_we;
   logic              mem_burst;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wmask;
   logic              mem_ack;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;
   logic              mem_done;

   modport master (
      input  vid_req, vid_addr,
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
      input  aux_req, aux_we, aux_addr, aux_wdata, aux_wmask,
      input  mem_ack, mem_rvalid, mem_rdata, mem_done,
      output vid_rvalid, vid_ack, cpu_rvalid, cpu_ack, aux_rvalid, aux_ack,
      output rdata,
      output mem_req, mem_we, mem_burst, mem_addr, mem_wdata, mem_wmask
   );

   modport slave (
      output vid_req, vid_addr,
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_wmask,
      output aux_req, aux_we, aux_addr, aux_wdata, aux_wmask,
      output mem_ack, mem_rvalid, mem_rdata, mem_done,
      input  vid_rvalid, vid_ack, cpu_rvalid, cpu_ack, aux_rvalid, aux_ack,
      input  rdata,
      input  mem_req, mem_we, mem_burst, mem_addr, mem_wdata, mem_wmask
   );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one SDRAM controller port between the video fetch
// (burst reads, top priority with a starvation guard), the CPU and an aux
// port (round-robin between the two). One transaction in flight at a time.
// Optional feature macro: SDRAM_ARB_AUX_EN -- when defined the aux port takes
// part in arbitration; otherwise its inputs are ignored and its strobes are 0.
module sdram_arbiter #(
   parameter int ADDR_W     = 22,
   parameter int BURST_LEN  = 8,
   parameter int STARVE_MAX = 16
) (
   input logic             clk_sdram,
   input logic             rst,
   sdram_arbiter_if.master bus
);
   localparam int CNT_W = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0]  STARVE_LIM = CNT_W'(STARVE_MAX);
   localparam logic [ADDR_W-1:0] BURST_MASK = ~ADDR_W'(BURST_LEN - 1);
`ifdef SDRAM_ARB_AUX_EN
   localparam logic AUX_EN = 1'b1;
`else
   localparam logic AUX_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;
   typedef enum logic [1:0] {OWN_VID = 2'd0, OWN_CPU = 2'd1, OWN_AUX = 2'd2} owner_t;

   state_t            state_q, state_d;
   owner_t            owner_q, owner_d, grant_own;
   logic              rr_q, rr_d;            // 0: CPU is next in line, 1: aux
   logic [CNT_W-1:0]  starve_q, starve_d;
   logic              mem_we_q, mem_we_d;
   logic              mem_burst_q, mem_burst_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_wmask_q, mem_wmask_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              vid_rvalid_q, vid_rvalid_d, cpu_rvalid_q, cpu_rvalid_d;
   logic              aux_rvalid_q, aux_rvalid_d;
   logic              vid_ack_q, vid_ack_d, cpu_ack_q, cpu_ack_d, aux_ack_q, aux_ack_d;
   logic              aux_req_eff, other_pend, starved, grant_any, grant_en;
   logic              mem_req, active;

   assign aux_req_eff = AUX_EN & bus.aux_req;
   assign other_pend  = bus.cpu_req | aux_req_eff;
   assign starved     = other_pend && (starve_q == STARVE_LIM);
   // The cycle an ack pulses is skipped so the finished client can drop its request.
   assign grant_en    = (state_q == IDLE) && !(vid_ack_q | cpu_ack_q | aux_ack_q);
   assign grant_any   = bus.vid_req | other_pend;

   // Choose the next owner: video unless starved, otherwise round-robin CPU/aux
   always_comb begin
      grant_own = OWN_VID;
      if (!bus.vid_req || starved) begin
         if (rr_q == 1'b0) begin
            if (bus.cpu_req) grant_own = OWN_CPU;
            else             grant_own = OWN_AUX;
         end else begin
            if (aux_req_eff) grant_own = OWN_AUX;
            else             grant_own = OWN_CPU;
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk_sdram) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // FSM next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (grant_en && grant_any) state_d = ISSUE;
         ISSUE: begin
            if (bus.mem_ack) begin
               if (bus.mem_done) state_d = IDLE;
               else              state_d = WAIT;
            end
         end
         WAIT:  if (bus.mem_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // FSM outputs: request while issuing; responses accepted from the ack cycle on
   always_comb begin
      mem_req = (state_q == ISSUE);
      active  = (state_q == WAIT) || ((state_q == ISSUE) && bus.mem_ack);
   end

   // Command latching, arbitration bookkeeping and response steering
   always_comb begin
      owner_d      = owner_q;
      rr_d         = rr_q;
      starve_d     = starve_q;
      mem_we_d     = mem_we_q;
      mem_burst_d  = mem_burst_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_wmask_d  = mem_wmask_q;
      rdata_d      = rdata_q;
      vid_rvalid_d = 1'b0;
      cpu_rvalid_d = 1'b0;
      aux_rvalid_d = 1'b0;
      vid_ack_d    = 1'b0;
      cpu_ack_d    = 1'b0;
      aux_ack_d    = 1'b0;
      if (grant_en && grant_any) begin
         owner_d = grant_own;
         unique case (grant_own)
            OWN_VID: begin
               mem_we_d    = 1'b0;
               mem_burst_d = 1'b1;
               mem_addr_d  = bus.vid_addr & BURST_MASK;
               mem_wdata_d = '0;
               mem_wmask_d = '0;
            end
            OWN_CPU: begin
               mem_we_d    = bus.cpu_we;
               mem_burst_d = 1'b0;
               mem_addr_d  = bus.cpu_addr;
               mem_wdata_d = bus.cpu_wdata;
               mem_wmask_d = bus.cpu_wmask;
               rr_d        = AUX_EN;
            end
            default: begin
               mem_we_d    = bus.aux_we;
               mem_burst_d = 1'b0;
               mem_addr_d  = bus.aux_addr;
               mem_wdata_d = bus.aux_wdata;
               mem_wmask_d = bus.aux_wmask;
               rr_d        = 1'b0;
            end
         endcase
         if (grant_own != OWN_VID)       starve_d = '0;
         else if (starve_q != STARVE_LIM) starve_d = starve_q + CNT_W'(1);
      end
      if (!other_pend) starve_d = '0;
      if (active) begin
         if (bus.mem_rvalid && !mem_we_q) begin
            rdata_d = bus.mem_rdata;
            unique case (owner_q)
               OWN_VID: vid_rvalid_d = 1'b1;
               OWN_CPU: cpu_rvalid_d = 1'b1;
               default: aux_rvalid_d = 1'b1;
            endcase
         end
         if (bus.mem_done) begin
            unique case (owner_q)
               OWN_VID: vid_ack_d = 1'b1;
               OWN_CPU: cpu_ack_d = 1'b1;
               default: aux_ack_d = 1'b1;
            endcase
         end
      end
   end

   // Registers for owner, pointer, counter, command fields and response strobes
   always_ff @(posedge clk_sdram) begin
      if (rst) begin
         owner_q      <= OWN_VID;
         rr_q         <= 1'b0;
         starve_q     <= '0;
         mem_we_q     <= 1'b0;
         mem_burst_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_wmask_q  <= '0;
         rdata_q      <= '0;
         vid_rvalid_q <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         aux_rvalid_q <= 1'b0;
         vid_ack_q    <= 1'b0;
         cpu_ack_q    <= 1'b0;
         aux_ack_q    <= 1'b0;
      end else begin
         owner_q      <= owner_d;
         rr_q         <= rr_d;
         starve_q     <= starve_d;
         mem_we_q     <= mem_we_d;
         mem_burst_q  <= mem_burst_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_wmask_q  <= mem_wmask_d;
         rdata_q      <= rdata_d;
         vid_rvalid_q <= vid_rvalid_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         aux_rvalid_q <= aux_rvalid_d;
         vid_ack_q    <= vid_ack_d;
         cpu_ack_q    <= cpu_ack_d;
         aux_ack_q    <= aux_ack_d;
      end
   end

   assign bus.mem_req    = mem_req;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_burst  = mem_burst_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.mem_wmask  = mem_wmask_q;
   assign bus.rdata      = rdata_q;
   assign bus.vid_rvalid = vid_rvalid_q;
   assign bus.vid_ack    = vid_ack_q;
   assign bus.cpu_rvalid = cpu_rvalid_q;
   assign bus.cpu_ack    = cpu_ack_q;
   assign bus.aux_rvalid = AUX_EN & aux_rvalid_q;
   assign bus.aux_ack    = AUX_EN & aux_ack_q;
endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench for sdram_arbiter with a hand-driven
// controller model. Works with SDRAM_ARB_AUX_EN defined or undefined.
module tb_sdram_arbiter;
   localparam int ADDR_W = 22;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   int   vid_rv_cnt = 0, vid_ack_cnt = 0, cpu_rv_cnt = 0, cpu_ack_cnt = 0;
   int   aux_rv_cnt = 0, aux_ack_cnt = 0;
   logic [31:0]       vid_data[$];
   logic [ADDR_W-1:0] grant_log[$];
   logic              mem_req_prev = 1'b0;

   sdram_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

   sdram_arbiter #(.ADDR_W(ADDR_W), .BURST_LEN(8), .STARVE_MAX(16)) dut (
      .clk_sdram(clk),
      .rst      (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // passive monitor: counts strobes and logs the address of every new grant
   always @(negedge clk) begin
      if (bus.vid_rvalid === 1'b1) begin vid_rv_cnt++; vid_data.push_back(bus.rdata); end
      if (bus.vid_ack === 1'b1) vid_ack_cnt++;
      if (bus.cpu_rvalid === 1'b1) cpu_rv_cnt++;
      if (bus.cpu_ack === 1'b1) cpu_ack_cnt++;
      if (bus.aux_rvalid === 1'b1) aux_rv_cnt++;
      if (bus.aux_ack === 1'b1) aux_ack_cnt++;
      if (bus.mem_req === 1'b1 && mem_req_prev !== 1'b1) grant_log.push_back(bus.mem_addr);
      mem_req_prev = bus.mem_req;
   end

   initial begin
      #400000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic clear_mon();
      vid_rv_cnt = 0; vid_ack_cnt = 0; cpu_rv_cnt = 0; cpu_ack_cnt = 0;
      aux_rv_cnt = 0; aux_ack_cnt = 0;
      vid_data.delete();
      grant_log.delete();
   endtask

   task automatic drive_idle();
      bus.vid_req = 0; bus.vid_addr = '0;
      bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_wmask = '0;
      bus.aux_req = 0; bus.aux_we = 0; bus.aux_addr = '0; bus.aux_wdata = '0; bus.aux_wmask = '0;
      bus.mem_ack = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0; bus.mem_done = 0;
   endtask

   task automatic do_reset();
      drive_idle();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // controller model: wait for mem_req, ack, return beats, then done.
   // Returns at the negedge where the owner's ack is visible.
   task automatic serve(input int beats, input logic [31:0] d0, output logic ok);
      int t = 0;
      ok = 1'b1;
      while (bus.mem_req !== 1'b1 && t < 64) begin @(negedge clk); t++; end
      if (bus.mem_req !== 1'b1) begin ok = 1'b0; return; end
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      for (int i = 0; i < beats; i++) begin
         bus.mem_rvalid = 1'b1;
         bus.mem_rdata  = d0 + 32'(i);
         @(negedge clk);
      end
      bus.mem_rvalid = 1'b0;
      bus.mem_done   = 1'b1;
      @(negedge clk);
      bus.mem_done   = 1'b0;
   endtask

   task automatic test_reset();
      drive_idle();
      bus.vid_req = 1'b1;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b want 0", bus.mem_req); end
      checks++; if ({bus.mem_we, bus.mem_burst} !== 2'b00) begin errors++; $display("FAIL reset_we_burst got %b want 00", {bus.mem_we, bus.mem_burst}); end
      checks++; if (bus.mem_addr !== '0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", bus.mem_addr); end
      checks++; if ({bus.mem_wdata, bus.mem_wmask} !== 36'h0) begin errors++; $display("FAIL reset_wdata_wmask got %h want 0", {bus.mem_wdata, bus.mem_wmask}); end
      checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", bus.rdata); end
      checks++;
      if ({bus.vid_rvalid, bus.vid_ack, bus.cpu_rvalid, bus.cpu_ack, bus.aux_rvalid, bus.aux_ack} !== 6'b0) begin
         errors++;
         $display("FAIL reset_strobes got %b want 000000",
                  {bus.vid_rvalid, bus.vid_ack, bus.cpu_rvalid, bus.cpu_ack, bus.aux_rvalid, bus.aux_ack});
      end
      bus.vid_req = 1'b0;
      rst = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL idle_no_req got %b want 0", bus.mem_req); end
   endtask

   task automatic test_cpu_read();
      clear_mon();
      bus.cpu_addr = 22'h000123; bus.cpu_we = 1'b0; bus.cpu_req = 1'b1;
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b1) begin errors++; $display("FAIL cpu_grant_latency mem_req got %b want 1", bus.mem_req); end
      checks++; if ({bus.mem_burst, bus.mem_we} !== 2'b00) begin errors++; $display("FAIL cpu_burst_we got %b want 00", {bus.mem_burst, bus.mem_we}); end
      checks++; if (bus.mem_addr !== 22'h000123) begin errors++; $display("FAIL cpu_addr got %h want 000123", bus.mem_addr); end
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL cpu_req_drop got %b want 0", bus.mem_req); end
      checks++; if (bus.mem_addr !== 22'h000123) begin errors++; $display("FAIL cpu_addr_hold got %h want 000123", bus.mem_addr); end
      bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
      @(negedge clk);
      bus.mem_rvalid = 1'b0;
      checks++; if (bus.cpu_rvalid !== 1'b1) begin errors++; $display("FAIL cpu_rvalid got %b want 1", bus.cpu_rvalid); end
      checks++; if (bus.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_rdata got %h want deadbeef", bus.rdata); end
      checks++; if (bus.cpu_ack !== 1'b0) begin errors++; $display("FAIL cpu_ack_early got %b want 0", bus.cpu_ack); end
      bus.mem_done = 1'b1;
      @(negedge clk);
      bus.mem_done = 1'b0;
      checks++; if ({bus.cpu_ack, bus.cpu_rvalid} !== 2'b10) begin errors++; $display("FAIL cpu_ack got %b want 10", {bus.cpu_ack, bus.cpu_rvalid}); end
      bus.cpu_req = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (cpu_ack_cnt != 1 || cpu_rv_cnt != 1) begin errors++; $display("FAIL cpu_pulse_counts got ack %0d rv %0d want 1 1", cpu_ack_cnt, cpu_rv_cnt); end
   endtask

   task automatic test_cpu_write();
      logic ok;
      clear_mon();
      bus.cpu_addr = 22'h000200; bus.cpu_we = 1'b1; bus.cpu_wdata = 32'hCAFEF00D; bus.cpu_wmask = 4'b0101;
      bus.cpu_req = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.mem_we, bus.mem_wdata, bus.mem_wmask} !== {1'b1, 1'b1, 32'hCAFEF00D, 4'b0101}) begin
         errors++;
         $display("FAIL wr_cmd got req %b we %b wd %h wm %b want 1 1 cafef00d 0101",
                  bus.mem_req, bus.mem_we, bus.mem_wdata, bus.mem_wmask);
      end
      serve(1, 32'h55555555, ok);
      checks++; if (!ok || bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL wr_ack got ok %b ack %b want 1 1", ok, bus.cpu_ack); end
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (cpu_rv_cnt != 0) begin errors++; $display("FAIL wr_no_rvalid got %0d want 0", cpu_rv_cnt); end
      checks++; if (bus.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rdata_kept got %h want deadbeef", bus.rdata); end
   endtask

   task automatic test_video_burst();
      logic ok;
      int   bad = 0;
      clear_mon();
      bus.vid_addr = 22'h001000; bus.vid_req = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.mem_burst, bus.mem_we, bus.mem_addr} !== {1'b1, 1'b1, 1'b0, 22'h001000}) begin
         errors++;
         $display("FAIL vid_cmd got req %b burst %b we %b addr %h want 1 1 0 001000",
                  bus.mem_req, bus.mem_burst, bus.mem_we, bus.mem_addr);
      end
      serve(8, 32'hA0000000, ok);
      checks++; if (!ok || bus.vid_ack !== 1'b1) begin errors++; $display("FAIL vid_ack got ok %b ack %b want 1 1", ok, bus.vid_ack); end
      bus.vid_req = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (vid_rv_cnt != 8 || vid_ack_cnt != 1) begin errors++; $display("FAIL vid_counts got rv %0d ack %0d want 8 1", vid_rv_cnt, vid_ack_cnt); end
      for (int i = 0; i < vid_data.size() && i < 8; i++)
         if (vid_data[i] !== 32'hA0000000 + 32'(i)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL vid_data_order got %0d wrong words want 0", bad); end
      checks++; if (cpu_rv_cnt != 0 || cpu_ack_cnt != 0) begin errors++; $display("FAIL vid_cpu_quiet got rv %0d ack %0d want 0 0", cpu_rv_cnt, cpu_ack_cnt); end
   endtask

   task automatic test_back_to_back();
      logic ok;
      clear_mon();
      bus.vid_addr = 22'h001000; bus.cpu_addr = 22'h000300; bus.cpu_we = 1'b0;
      bus.vid_req = 1'b1; bus.cpu_req = 1'b1;
      serve(8, 32'hB0000000, ok);
      checks++; if (!ok || bus.vid_ack !== 1'b1) begin errors++; $display("FAIL b2b_vid_ack got ok %b ack %b want 1 1", ok, bus.vid_ack); end
      bus.vid_req = 1'b0;
      @(negedge clk);
      checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL b2b_gap got mem_req %b want 0", bus.mem_req); end
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.mem_addr} !== {1'b1, 22'h000300}) begin
         errors++; $display("FAIL b2b_cpu_grant got req %b addr %h want 1 000300", bus.mem_req, bus.mem_addr);
      end
      serve(1, 32'h0BADF00D, ok);
      checks++; if (!ok || bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL b2b_cpu_ack got ok %b ack %b want 1 1", ok, bus.cpu_ack); end
      bus.cpu_req = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (grant_log.size() != 2) begin
         errors++; $display("FAIL b2b_order got %0d grants want 2", grant_log.size());
      end else if (grant_log[0] !== 22'h001000 || grant_log[1] !== 22'h000300) begin
         errors++; $display("FAIL b2b_order got %h %h want 001000 000300", grant_log[0], grant_log[1]);
      end
   endtask

   task automatic test_starvation();
      logic ok;
      int   timeouts = 0;
      int   vid_grants = 0;
      clear_mon();
      bus.vid_addr = 22'h002000; bus.cpu_addr = 22'h000456; bus.cpu_we = 1'b0;
      bus.vid_req = 1'b1; bus.cpu_req = 1'b1;
      for (int i = 0; i < 16; i++) begin
         serve(8, 32'(i) << 8, ok);
         if (!ok) timeouts++;
      end
      serve(1, 32'h77770000, ok);
      if (!ok) timeouts++;
      serve(8, 32'h88880000, ok);
      if (!ok) timeouts++;
      bus.vid_req = 1'b0; bus.cpu_req = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (timeouts != 0) begin errors++; $display("FAIL starve_timeouts got %0d want 0", timeouts); end
      for (int i = 0; i < 16 && i < grant_log.size(); i++)
         if (grant_log[i] === 22'h002000) vid_grants++;
      checks++; if (vid_grants != 16) begin errors++; $display("FAIL starve_vid_first got %0d want 16", vid_grants); end
      checks++;
      if (grant_log.size() != 18) begin
         errors++; $display("FAIL starve_grant_count got %0d want 18", grant_log.size());
      end else if (grant_log[16] !== 22'h000456 || grant_log[17] !== 22'h002000) begin
         errors++; $display("FAIL starve_cpu_then_vid got %h %h want 000456 002000", grant_log[16], grant_log[17]);
      end
      checks++; if (cpu_ack_cnt != 1 || vid_ack_cnt != 17) begin errors++; $display("FAIL starve_acks got cpu %0d vid %0d want 1 17", cpu_ack_cnt, vid_ack_cnt); end
   endtask

   task automatic test_round_robin();
      logic              ok;
      int                bad = 0;
      logic [ADDR_W-1:0] exp_addr [3];
      int                exp_cpu_acks;
      int                exp_aux_acks;
`ifdef SDRAM_ARB_AUX_EN
      exp_addr[0] = 22'h000010; exp_addr[1] = 22'h000020; exp_addr[2] = 22'h000010;
      exp_cpu_acks = 2; exp_aux_acks = 1;
`else
      exp_addr[0] = 22'h000010; exp_addr[1] = 22'h000010; exp_addr[2] = 22'h000010;
      exp_cpu_acks = 3; exp_aux_acks = 0;
`endif
      do_reset();
      clear_mon();
      bus.cpu_addr = 22'h000010; bus.aux_addr = 22'h000020;
      bus.cpu_req = 1'b1; bus.aux_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         serve(1, 32'h100 + 32'(i), ok);
         if (!ok) bad++;
      end
      bus.cpu_req = 1'b0; bus.aux_req = 1'b0;
      repeat (3) @(negedge clk);
      if (grant_log.size() != 3) bad++;
      for (int i = 0; i < 3 && i < grant_log.size(); i++)
         if (grant_log[i] !== exp_addr[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rr_order got %0d wrong grants want 0", bad); end
      checks++; if (cpu_ack_cnt != exp_cpu_acks) begin errors++; $display("FAIL rr_cpu_acks got %0d want %0d", cpu_ack_cnt, exp_cpu_acks); end
      checks++;
      if (aux_ack_cnt != exp_aux_acks || aux_rv_cnt != exp_aux_acks) begin
         errors++; $display("FAIL rr_aux_acks got ack %0d rv %0d want %0d", aux_ack_cnt, aux_rv_cnt, exp_aux_acks);
      end
   endtask

   task automatic test_reset_mid();
      logic ok;
      clear_mon();
      bus.vid_addr = 22'h003000; bus.vid_req = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b1;
      @(negedge clk);
      bus.mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hC0000000 + 32'(i);
         @(negedge clk);
      end
      bus.mem_rvalid = 1'b0;
      bus.vid_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.mem_req, bus.mem_burst, bus.vid_rvalid, bus.vid_ack} !== 4'b0000 || bus.mem_addr !== '0 || bus.rdata !== 32'h0) begin
         errors++;
         $display("FAIL rstmid_outputs got req %b burst %b rv %b ack %b addr %h rdata %h want all 0",
                  bus.mem_req, bus.mem_burst, bus.vid_rvalid, bus.vid_ack, bus.mem_addr, bus.rdata);
      end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (vid_ack_cnt != 0 || vid_rv_cnt != 3) begin errors++; $display("FAIL rstmid_no_ack got ack %0d rv %0d want 0 3", vid_ack_cnt, vid_rv_cnt); end
      bus.cpu_addr = 22'h000077; bus.cpu_we = 1'b0; bus.cpu_req = 1'b1;
      serve(1, 32'h12345678, ok);
      checks++; if (!ok || bus.cpu_ack !== 1'b1) begin errors++; $display("FAIL rstmid_cpu_ack got ok %b ack %b want 1 1", ok, bus.cpu_ack); end
      bus.cpu_req = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (cpu_rv_cnt != 1 || bus.rdata !== 32'h12345678) begin
         errors++; $display("FAIL rstmid_cpu_read got rv %0d rdata %h want 1 12345678", cpu_rv_cnt, bus.rdata);
      end
   endtask

   initial begin
      drive_idle();
      test_reset();
      test_cpu_read();
      test_cpu_write();
      test_video_burst();
      test_back_to_back();
      test_starvation();
      test_round_robin();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
